// File: rtl/lut_pkg.sv
// ============================================================================
// lut_pkg : shared sizes, entry type and loader state encoding for the LUT.
// Rev 1.0
// ============================================================================
`default_nettype none

package lut_pkg;

    localparam int ENTRIES = 16;
    localparam int IDX_W   = 4;
    localparam int OUT_W   = 10;
    localparam int STATE_W = 2;

    typedef logic [OUT_W-1:0] lut_entry_t;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } lut_ld_state_t;

endpackage

`default_nettype wire

// File: rtl/lut_loader_if.sv
// ============================================================================
// lut_loader_if : data-memory read bus between the LUT loader and memory.
// Rev 1.0
// ============================================================================
`default_nettype none

interface lut_loader_if #(
    parameter int DM_AW = 8
);
    logic [DM_AW-1:0] MemAddr;
    logic             MemRdEn;
    logic [7:0]       MemData;

    modport master (
        output MemAddr,
        output MemRdEn,
        input  MemData
    );

    modport slave (
        input  MemAddr,
        input  MemRdEn,
        output MemData
    );
endinterface

`default_nettype wire

// File: rtl/lut_regfile.sv
// ============================================================================
// lut_regfile : ENTRIES x OUT_W table, one synchronous write, one async read.
// Rev 1.0
// ============================================================================
`default_nettype none

module lut_regfile #(
    parameter int ENTRIES = lut_pkg::ENTRIES,
    parameter int IDX_W   = lut_pkg::IDX_W,
    parameter int OUT_W   = lut_pkg::OUT_W
) (
    input  wire logic             Clk,
    input  wire logic             Reset,
    input  wire logic             WrEn,
    input  wire logic [IDX_W-1:0] WrIdx,
    input  wire logic [OUT_W-1:0] WrData,
    input  wire logic [IDX_W-1:0] Index,
    output logic      [OUT_W-1:0] Out
);

    logic [OUT_W-1:0] tbl_q [ENTRIES];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_q[i] <= '0;
            end
        end else if (WrEn) begin
            tbl_q[WrIdx] <= WrData;
        end
    end

    // A same-cycle write to Index only becomes visible after the edge.
    assign Out = tbl_q[Index];

endmodule

`default_nettype wire

// File: rtl/lut_loader.sv
// ============================================================================
// lut_loader : streams 2*ENTRIES bytes from data memory into the lookup table.
// Rev 1.0
// ============================================================================
`default_nettype none

module lut_loader
    import lut_pkg::*;
#(
    parameter int               ENTRIES   = lut_pkg::ENTRIES,
    parameter int               IDX_W     = lut_pkg::IDX_W,
    parameter int               OUT_W     = lut_pkg::OUT_W,
    parameter int               DM_AW     = 8,
    parameter logic [DM_AW-1:0] BASE_ADDR = DM_AW'(8'hC0)
) (
    input  wire logic             Clk,
    input  wire logic             Reset,
    input  wire logic             Start,
    output logic                  Busy,
    output logic                  Done,
    input  wire logic [IDX_W-1:0] Index,
    output logic      [OUT_W-1:0] Out,
    lut_loader_if.master          mem
);

    localparam int               PTR_W    = IDX_W + 2;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(2 * ENTRIES - 1);

    lut_ld_state_t    state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [IDX_W:0]   cap_ptr_q;
    logic             cap_vld_q;
    logic [7:0]       lo_q;

    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [OUT_W-1:0] wr_data;
    logic             unused_hi;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (Start) state_d = LOAD;
            LOAD:    if (ptr_q == LAST_PTR) state_d = DRAIN;
            DRAIN:   state_d = DONE;
            DONE:    if (Start) state_d = LOAD;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem.MemAddr = '0;
        mem.MemRdEn = 1'b0;
        Busy        = 1'b0;
        Done        = 1'b0;
        case (state_q)
            LOAD: begin
                mem.MemAddr = BASE_ADDR + DM_AW'(ptr_q);
                mem.MemRdEn = 1'b1;
                Busy        = 1'b1;
            end
            DRAIN:   Busy = 1'b1;
            DONE:    Done = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == LOAD) begin
            ptr_d = ptr_q + 1'b1;
        end else if ((state_q == IDLE || state_q == DONE) && Start) begin
            ptr_d = '0;
        end
    end

    // Each returning byte is tagged by the pointer that was issued one cycle earlier.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ptr_q     <= '0;
            cap_ptr_q <= '0;
            cap_vld_q <= 1'b0;
            lo_q      <= '0;
        end else begin
            ptr_q     <= ptr_d;
            cap_ptr_q <= ptr_q[IDX_W:0];
            cap_vld_q <= (state_q == LOAD);
            if (cap_vld_q && !cap_ptr_q[0]) begin
                lo_q <= mem.MemData;
            end
        end
    end

    assign wr_en     = cap_vld_q & cap_ptr_q[0];
    assign wr_idx    = cap_ptr_q[IDX_W:1];
    assign wr_data   = {mem.MemData[OUT_W-9:0], lo_q};
    assign unused_hi = ^mem.MemData[7:OUT_W-8];

    lut_regfile #(
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W),
        .OUT_W   (OUT_W)
    ) u_regfile (
        .Clk    (Clk),
        .Reset  (Reset),
        .WrEn   (wr_en),
        .WrIdx  (wr_idx),
        .WrData (wr_data),
        .Index  (Index),
        .Out    (Out)
    );

endmodule

`default_nettype wire
